// File: rtl/user_io_pkg.sv
// Shared definitions for the user GPIO controller: register offsets, reset constants, bus FSM states.
// No logic; constants only.
// No flow control; consumed by user_io_ctrl and its testbench.
package user_io_pkg;

    // Register offsets inside the 256-byte window
    localparam logic [7:0] OFF_OUT = 8'h00;
    localparam logic [7:0] OFF_OEB = 8'h04;
    localparam logic [7:0] OFF_IN  = 8'h08;
    localparam logic [7:0] OFF_IE  = 8'h0C;
    localparam logic [7:0] OFF_IS  = 8'h10;
    localparam logic [7:0] OFF_OWN = 8'h14;

    // Reset values
    localparam logic [15:0] OUT_RST = 16'h0000;
    localparam logic [15:0] OEB_RST = 16'hFFFF;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_ACK  = 1'b1
    } bus_state_t;

endpackage

// File: rtl/user_io_sync.sv
// Multi-stage input synchronizer with rising-edge detector on the synchronized value.
// Latency: STAGES clocks to q; rise is combinational from q and its one-cycle-old copy.
// No backpressure; samples every clock.
// Ports: clk/rst (sync active-high), d_in (async pads), q (synchronized), rise (q=1, previous q=0).
module user_io_sync #(
    parameter int WIDTH  = 16,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d_in,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] rise
);

    logic [STAGES-1:0][WIDTH-1:0] stage_q, stage_d;
    logic [WIDTH-1:0]             prev_q, prev_d;

    always_comb begin
        stage_d = {stage_q[STAGES-2:0], d_in};
        prev_d  = stage_q[STAGES-1];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stage_q <= '0;
            prev_q  <= '0;
        end else begin
            stage_q <= stage_d;
            prev_q  <= prev_d;
        end
    end

    assign q    = stage_q[STAGES-1];
    assign rise = stage_q[STAGES-1] & ~prev_q;

endmodule

// File: rtl/user_io_ctrl.sv
// Wishbone register bank for 16 user pads with per-pin Wishbone/LA ownership and rising-edge interrupt.
// Latency: ack and read data one cycle after stb; writes visible on pads in that same ack cycle.
// No wait states; a held stb is acked every other cycle (IDLE/ACK alternation).
// Ports: wb_clk_i/wb_rst_i, wbs_* classic slave, io_in/io_out/io_oeb pads,
//        la_data_in (out values [15:0], oeb values [31:16]), la_data_out (synced pads), irq[0] GPIO.
module user_io_ctrl
    import user_io_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR   = 32'h3000_0000,
    parameter int          NPINS       = 16,
    parameter int          SYNC_STAGES = 2
) (
    input  logic             wb_clk_i,
    input  logic             wb_rst_i,
    input  logic             wbs_cyc_i,
    input  logic             wbs_stb_i,
    input  logic             wbs_we_i,
    input  logic [3:0]       wbs_sel_i,
    input  logic [31:0]      wbs_adr_i,
    input  logic [31:0]      wbs_dat_i,
    output logic             wbs_ack_o,
    output logic [31:0]      wbs_dat_o,
    input  logic [NPINS-1:0] io_in,
    output logic [NPINS-1:0] io_out,
    output logic [NPINS-1:0] io_oeb,
    input  logic [31:0]      la_data_in,
    output logic [NPINS-1:0] la_data_out,
    output logic [2:0]       irq
);

    bus_state_t  state_q, state_d;
    logic        ack_q, ack_d;
    logic [31:0] dat_q, dat_d;
    logic [15:0] out_q, out_d;
    logic [15:0] oeb_q, oeb_d;
    logic [15:0] ie_q, ie_d;
    logic [15:0] is_q, is_d;
    logic [15:0] own_q, own_d;
    logic        irq_q, irq_d;

    logic [15:0] pin_sync, pin_rise;

    logic        req, hit, commit, wr;
    logic [7:0]  off;
    logic [15:0] be_mask, rd_val;

    // Upper sel/data lanes carry nothing in this 16-bit register map
    logic unused_lanes;
    assign unused_lanes = &{1'b0, wbs_sel_i[3:2], wbs_dat_i[31:16]};

    user_io_sync #(
        .WIDTH  (16),
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk  (wb_clk_i),
        .rst  (wb_rst_i),
        .d_in (io_in),
        .q    (pin_sync),
        .rise (pin_rise)
    );

    always_comb begin
        req     = wbs_cyc_i & wbs_stb_i;
        hit     = (wbs_adr_i[31:8] == BASE_ADDR[31:8]);
        off     = wbs_adr_i[7:0];
        // The access is committed on the IDLE->ACK edge only
        commit  = (state_q == ST_IDLE) && req;
        wr      = commit && wbs_we_i && hit;
        be_mask = {{8{wbs_sel_i[1]}}, {8{wbs_sel_i[0]}}};

        rd_val = 16'h0000;
        if (hit) begin
            case (off)
                OFF_OUT: rd_val = out_q;
                OFF_OEB: rd_val = oeb_q;
                OFF_IN:  rd_val = pin_sync;
                OFF_IE:  rd_val = ie_q;
                OFF_IS:  rd_val = is_q;
                OFF_OWN: rd_val = own_q;
                default: rd_val = 16'h0000;
            endcase
        end

        out_d = out_q;
        oeb_d = oeb_q;
        ie_d  = ie_q;
        own_d = own_q;
        is_d  = is_q;
        if (wr) begin
            case (off)
                OFF_OUT: out_d = (out_q & ~be_mask) | (wbs_dat_i[15:0] & be_mask);
                OFF_OEB: oeb_d = (oeb_q & ~be_mask) | (wbs_dat_i[15:0] & be_mask);
                OFF_IE:  ie_d  = (ie_q  & ~be_mask) | (wbs_dat_i[15:0] & be_mask);
                OFF_OWN: own_d = (own_q & ~be_mask) | (wbs_dat_i[15:0] & be_mask);
                OFF_IS:  is_d  = is_q & ~(wbs_dat_i[15:0] & be_mask);
                default: ;
            endcase
        end
        // A rising edge in the same cycle as a W1C keeps the bit set
        is_d = is_d | pin_rise;

        irq_d = |(is_q & ie_q);

        state_d = state_q;
        case (state_q)
            ST_IDLE: if (req) state_d = ST_ACK;
            ST_ACK:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        ack_d = commit;
        dat_d = (commit && !wbs_we_i) ? {16'h0000, rd_val} : 32'h0000_0000;
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q <= ST_IDLE;
            ack_q   <= 1'b0;
            dat_q   <= 32'h0000_0000;
            out_q   <= OUT_RST;
            oeb_q   <= OEB_RST;
            ie_q    <= 16'h0000;
            is_q    <= 16'h0000;
            own_q   <= 16'h0000;
            irq_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ack_q   <= ack_d;
            dat_q   <= dat_d;
            out_q   <= out_d;
            oeb_q   <= oeb_d;
            ie_q    <= ie_d;
            is_q    <= is_d;
            own_q   <= own_d;
            irq_q   <= irq_d;
        end
    end

    // Pad mux: owned pins follow the LA bus, others follow the register bank
    assign io_out = (own_q & la_data_in[15:0])  | (~own_q & out_q);
    assign io_oeb = (own_q & la_data_in[31:16]) | (~own_q & oeb_q);

    assign wbs_ack_o   = ack_q;
    assign wbs_dat_o   = dat_q;
    assign la_data_out = pin_sync;
    assign irq         = {2'b00, irq_q};

endmodule

// File: tb/tb_user_io_ctrl.sv
// Self-checking bench for user_io_ctrl against a transaction-level register model.
// Latency: bench drives on negedge, samples on negedge.
// No backpressure on the bench side; every wait is bounded.
module tb_user_io_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        wbs_cyc_i, wbs_stb_i, wbs_we_i;
    logic [3:0]  wbs_sel_i;
    logic [31:0] wbs_adr_i, wbs_dat_i;
    logic        wbs_ack_o;
    logic [31:0] wbs_dat_o;
    logic [15:0] io_in, io_out, io_oeb;
    logic [31:0] la_data_in;
    logic [15:0] la_data_out;
    logic [2:0]  irq;

    int errors = 0;
    int checks = 0;

    localparam logic [31:0] BASE = 32'h3000_0000;

    // Register model
    logic [15:0] m_out, m_oeb, m_ie, m_is, m_own, m_pins;

    always #5 clk = ~clk;

    user_io_ctrl dut (
        .wb_clk_i    (clk),
        .wb_rst_i    (rst),
        .wbs_cyc_i   (wbs_cyc_i),
        .wbs_stb_i   (wbs_stb_i),
        .wbs_we_i    (wbs_we_i),
        .wbs_sel_i   (wbs_sel_i),
        .wbs_adr_i   (wbs_adr_i),
        .wbs_dat_i   (wbs_dat_i),
        .wbs_ack_o   (wbs_ack_o),
        .wbs_dat_o   (wbs_dat_o),
        .io_in       (io_in),
        .io_out      (io_out),
        .io_oeb      (io_oeb),
        .la_data_in  (la_data_in),
        .la_data_out (la_data_out),
        .irq         (irq)
    );

    function automatic logic [15:0] exp_pad_out();
        logic [15:0] r;
        for (int i = 0; i < 16; i++) r[i] = m_own[i] ? la_data_in[i] : m_out[i];
        return r;
    endfunction

    function automatic logic [15:0] exp_pad_oeb();
        logic [15:0] r;
        for (int i = 0; i < 16; i++) r[i] = m_own[i] ? la_data_in[16+i] : m_oeb[i];
        return r;
    endfunction

    function automatic logic [31:0] exp_read(input logic [31:0] a);
        if (a[31:8] != BASE[31:8]) return 32'h0;
        case (a[7:0])
            8'h00:   return {16'h0, m_out};
            8'h04:   return {16'h0, m_oeb};
            8'h08:   return {16'h0, m_pins};
            8'h0C:   return {16'h0, m_ie};
            8'h10:   return {16'h0, m_is};
            8'h14:   return {16'h0, m_own};
            default: return 32'h0;
        endcase
    endfunction

    task automatic model_write(input logic [31:0] a, input logic [3:0] s, input logic [31:0] d);
        logic [15:0] m;
        m = {{8{s[1]}}, {8{s[0]}}};
        if (a[31:8] == BASE[31:8]) begin
            case (a[7:0])
                8'h00: m_out = (m_out & ~m) | (d[15:0] & m);
                8'h04: m_oeb = (m_oeb & ~m) | (d[15:0] & m);
                8'h0C: m_ie  = (m_ie  & ~m) | (d[15:0] & m);
                8'h14: m_own = (m_own & ~m) | (d[15:0] & m);
                8'h10: m_is  = m_is & ~(d[15:0] & m);
                default: ;
            endcase
        end
    endtask

    task automatic model_reset();
        m_out = 16'h0000; m_oeb = 16'hFFFF; m_ie = 16'h0; m_is = 16'h0; m_own = 16'h0;
        m_pins = 16'h0;
    endtask

    // One Wishbone transfer: returns read data, pad state and ack latency seen in the ack cycle
    task automatic wb_xfer(input logic w, input logic [31:0] a, input logic [3:0] s, input logic [31:0] d,
                           output logic [31:0] rd, output logic [15:0] po, output logic [15:0] pe,
                           output int lat);
        logic got;
        got = 1'b0; rd = '0; po = '0; pe = '0; lat = -1;
        @(negedge clk);
        wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = w;
        wbs_adr_i = a; wbs_sel_i = s; wbs_dat_i = d;
        for (int i = 1; i <= 4 && !got; i++) begin
            @(negedge clk);
            if (wbs_ack_o === 1'b1) begin
                got = 1'b1; rd = wbs_dat_o; po = io_out; pe = io_oeb; lat = i;
            end
        end
        wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0; wbs_we_i = 1'b0;
        @(negedge clk);
        checks++;
        if (!got) begin
            errors++;
            $display("FAIL wb_ack adr=%h: no ack within 4 cycles, ack required", a);
        end
        if (w) model_write(a, s, d);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; io_in = 16'h0;
        wbs_cyc_i = 0; wbs_stb_i = 0; wbs_we_i = 0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    // Change pads and let them settle through synchronizer, IS and irq
    task automatic set_pins(input logic [15:0] v);
        @(negedge clk);
        io_in  = v;
        m_is   = m_is | (v & ~m_pins);
        m_pins = v;
        repeat (5) @(negedge clk);
    endtask

    task automatic test_reset();
        logic [31:0] rd; logic [15:0] po, pe; int lat;
        logic [7:0] offs [6];
        offs = '{8'h00, 8'h04, 8'h08, 8'h0C, 8'h10, 8'h14};
        do_reset();
        checks++;
        if (io_oeb !== 16'hFFFF || io_out !== 16'h0 || irq !== 3'b0 || wbs_ack_o !== 1'b0 ||
            wbs_dat_o !== 32'h0 || la_data_out !== 16'h0) begin
            errors++;
            $display("FAIL reset_outputs oeb=%h out=%h irq=%b ack=%b dat=%h la=%h, required FFFF 0000 000 0 0 0",
                     io_oeb, io_out, irq, wbs_ack_o, wbs_dat_o, la_data_out);
        end
        foreach (offs[k]) begin
            wb_xfer(1'b0, BASE | {24'h0, offs[k]}, 4'hF, 32'h0, rd, po, pe, lat);
            checks++;
            if (rd !== exp_read(BASE | {24'h0, offs[k]})) begin
                errors++;
                $display("FAIL reset_reg off=%h got=%h required=%h", offs[k], rd, exp_read(BASE | {24'h0, offs[k]}));
            end
        end
    endtask

    task automatic test_write_mux();
        logic [31:0] rd; logic [15:0] po, pe; int lat;
        la_data_in = 32'h0;
        wb_xfer(1'b1, BASE + 32'h00, 4'h3, 32'h0000_A5A5, rd, po, pe, lat);
        checks++;
        if (po !== 16'hA5A5 || lat != 1) begin
            errors++;
            $display("FAIL write_out io_out=%h lat=%0d required A5A5 lat=1", po, lat);
        end
        wb_xfer(1'b1, BASE + 32'h04, 4'h3, 32'h0000_0000, rd, po, pe, lat);
        checks++;
        if (pe !== 16'h0000) begin
            errors++;
            $display("FAIL write_oeb io_oeb=%h required 0000", pe);
        end
        la_data_in = 32'h0000_3C3C;
        wb_xfer(1'b1, BASE + 32'h14, 4'h3, 32'h0000_00FF, rd, po, pe, lat);
        checks++;
        if (po !== 16'hA53C || pe !== 16'h0000 || po !== exp_pad_out()) begin
            errors++;
            $display("FAIL own_mux io_out=%h io_oeb=%h required A53C 0000", po, pe);
        end
    endtask

    task automatic test_byte_sel();
        logic [31:0] rd; logic [15:0] po, pe; int lat;
        wb_xfer(1'b1, BASE + 32'h00, 4'h3, 32'h0, rd, po, pe, lat);
        wb_xfer(1'b1, BASE + 32'h00, 4'b0010, 32'h0000_1234, rd, po, pe, lat);
        wb_xfer(1'b0, BASE + 32'h00, 4'hF, 32'h0, rd, po, pe, lat);
        checks++;
        if (rd !== 32'h0000_1200) begin
            errors++;
            $display("FAIL byte_sel1 got=%h required=00001200", rd);
        end
        wb_xfer(1'b1, BASE + 32'h00, 4'b1100, 32'hFFFF_FFFF, rd, po, pe, lat);
        wb_xfer(1'b0, BASE + 32'h00, 4'hF, 32'h0, rd, po, pe, lat);
        checks++;
        if (rd !== 32'h0000_1200) begin
            errors++;
            $display("FAIL byte_sel_upper got=%h required=00001200", rd);
        end
    endtask

    task automatic test_interrupt();
        logic [31:0] rd; logic [15:0] po, pe; int lat;
        do_reset();
        wb_xfer(1'b1, BASE + 32'h0C, 4'h3, 32'h0000_0001, rd, po, pe, lat);
        @(negedge clk);
        io_in = 16'h0001;
        @(negedge clk);
        checks++;
        if (la_data_out[0] !== 1'b0) begin
            errors++; $display("FAIL sync_edge1 la_out0=%b required 0", la_data_out[0]);
        end
        @(negedge clk);
        checks++;
        if (la_data_out[0] !== 1'b1) begin
            errors++; $display("FAIL sync_edge2 la_out0=%b required 1", la_data_out[0]);
        end
        @(negedge clk);
        checks++;
        if (irq !== 3'b000) begin
            errors++; $display("FAIL irq_edge3 irq=%b required 000", irq);
        end
        @(negedge clk);
        checks++;
        if (irq !== 3'b001) begin
            errors++; $display("FAIL irq_edge4 irq=%b required 001", irq);
        end
        m_is = m_is | 16'h0001; m_pins = 16'h0001;
        wb_xfer(1'b0, BASE + 32'h10, 4'hF, 32'h0, rd, po, pe, lat);
        checks++;
        if (rd !== 32'h0000_0001) begin
            errors++; $display("FAIL is_read got=%h required=00000001", rd);
        end
        wb_xfer(1'b1, BASE + 32'h10, 4'h1, 32'h0000_0001, rd, po, pe, lat);
        checks++;
        if (irq !== 3'b000) begin
            errors++; $display("FAIL irq_clear irq=%b required 000", irq);
        end
    endtask

    task automatic test_w1c_race();
        logic [31:0] rd; logic [15:0] po, pe; int lat;
        set_pins(m_pins | 16'h0008);
        set_pins(m_pins & ~16'h0008);
        @(negedge clk);
        io_in = m_pins | 16'h0008;
        @(negedge clk);
        // xfer drives stb on the next negedge, so commit lands on the edge that sets IS[3]
        wb_xfer(1'b1, BASE + 32'h10, 4'h1, 32'h0000_0008, rd, po, pe, lat);
        m_is = m_is | 16'h0008; m_pins = m_pins | 16'h0008;
        wb_xfer(1'b0, BASE + 32'h10, 4'hF, 32'h0, rd, po, pe, lat);
        checks++;
        if (rd[3] !== 1'b1 || rd !== exp_read(BASE + 32'h10)) begin
            errors++; $display("FAIL w1c_race IS=%h required=%h", rd, exp_read(BASE + 32'h10));
        end
        wb_xfer(1'b1, BASE + 32'h10, 4'h1, 32'h0000_0008, rd, po, pe, lat);
        wb_xfer(1'b0, BASE + 32'h10, 4'hF, 32'h0, rd, po, pe, lat);
        checks++;
        if (rd[3] !== 1'b0 || rd !== exp_read(BASE + 32'h10)) begin
            errors++; $display("FAIL w1c_plain IS=%h required=%h", rd, exp_read(BASE + 32'h10));
        end
    endtask

    task automatic test_random_regs();
        logic [31:0] rd, a, d, e; logic [15:0] po, pe; int lat;
        logic w; logic [3:0] s; int pick;
        for (int k = 0; k < 48; k++) begin
            if (k % 8 == 0) set_pins(16'($urandom));
            la_data_in = $urandom;
            pick = $urandom_range(0, 7);
            if (pick < 6)       a = BASE | 32'(pick * 4);
            else if (pick == 6) a = BASE | 32'({$urandom_range(6, 63), 2'b00});
            else                a = 32'h3100_0000 | 32'(4 * $urandom_range(0, 5));
            w = 1'($urandom);
            s = 4'($urandom);
            d = $urandom;
            e = exp_read(a);
            wb_xfer(w, a, s, d, rd, po, pe, lat);
            if (!w) begin
                checks++;
                if (rd !== e) begin
                    errors++; $display("FAIL rand_read adr=%h got=%h required=%h", a, rd, e);
                end
            end
            checks++;
            if (io_out !== exp_pad_out() || io_oeb !== exp_pad_oeb() || irq !== {2'b00, |(m_is & m_ie)}) begin
                errors++;
                $display("FAIL rand_pads adr=%h out=%h oeb=%h irq=%b required %h %h %b", a, io_out, io_oeb,
                         irq, exp_pad_out(), exp_pad_oeb(), {2'b00, |(m_is & m_ie)});
            end
        end
    endtask

    task automatic test_bus_corners();
        logic [31:0] rd; logic [15:0] po, pe; int lat; int n_ack;
        wb_xfer(1'b0, 32'h3000_0040, 4'hF, 32'h0, rd, po, pe, lat);
        checks++;
        if (rd !== 32'h0) begin errors++; $display("FAIL unmapped_off got=%h required=0", rd); end
        wb_xfer(1'b0, 32'h3100_0000, 4'hF, 32'h0, rd, po, pe, lat);
        checks++;
        if (rd !== 32'h0) begin errors++; $display("FAIL miss_window got=%h required=0", rd); end
        wb_xfer(1'b1, 32'h3100_0000, 4'h3, 32'h0000_FFFF, rd, po, pe, lat);
        wb_xfer(1'b0, BASE, 4'hF, 32'h0, rd, po, pe, lat);
        checks++;
        if (rd !== exp_read(BASE)) begin
            errors++; $display("FAIL miss_write_dropped OUT=%h required=%h", rd, exp_read(BASE));
        end
        @(negedge clk);
        wbs_cyc_i = 1; wbs_stb_i = 1; wbs_we_i = 0; wbs_adr_i = BASE; wbs_sel_i = 4'hF;
        n_ack = 0;
        repeat (6) begin
            @(negedge clk);
            if (wbs_ack_o === 1'b1) n_ack++;
        end
        wbs_cyc_i = 0; wbs_stb_i = 0;
        @(negedge clk);
        checks++;
        if (n_ack != 3) begin errors++; $display("FAIL held_stb acks=%0d required=3", n_ack); end
        @(negedge clk);
        wbs_cyc_i = 1; wbs_stb_i = 1; wbs_we_i = 1; wbs_adr_i = BASE; wbs_sel_i = 4'h3; wbs_dat_i = 32'h5555;
        @(negedge clk);
        checks++;
        if (wbs_ack_o !== 1'b1) begin errors++; $display("FAIL ack_before_rst ack=%b required 1", wbs_ack_o); end
        rst = 1'b1;
        wbs_cyc_i = 0; wbs_stb_i = 0; wbs_we_i = 0;
        @(negedge clk);
        checks++;
        if (wbs_ack_o !== 1'b0 || io_out !== 16'h0 || io_oeb !== 16'hFFFF) begin
            errors++;
            $display("FAIL rst_in_ack ack=%b out=%h oeb=%h required 0 0000 FFFF", wbs_ack_o, io_out, io_oeb);
        end
        io_in = 16'h0;
        @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        wbs_cyc_i = 0; wbs_stb_i = 0; wbs_we_i = 0;
        wbs_sel_i = 0; wbs_adr_i = 0; wbs_dat_i = 0;
        io_in = 0; la_data_in = 0;
        model_reset();
        test_reset();
        test_write_mux();
        test_byte_sel();
        test_interrupt();
        test_w1c_race();
        test_random_regs();
        test_bus_corners();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
